// File: rtl/rc_servo_pkg.sv
// Shared types and elaboration helpers for the RC servo core.
//   pw_t          : pulse-width / frame-counter type, wide enough for any
//                   practical frame length in clock cycles.
//   pw_mid()      : neutral pulse width, used before the first sample and
//                   while a channel is disabled.
//   pw_fits_frame : true when the widest pulse fits strictly inside a frame.
package rc_servo_pkg;

    localparam int PW_W = 24;

    typedef logic [PW_W-1:0] pw_t;

    function automatic pw_t pw_mid(input int pw_min, input int adc_w, input int scale_sh);
        return pw_t'(pw_min + ((1 << (adc_w - 1)) << scale_sh));
    endfunction

    function automatic bit pw_fits_frame(input int pw_min, input int adc_w,
                                         input int scale_sh, input int frame_cyc);
        return (pw_min + (((1 << adc_w) - 1) << scale_sh)) < frame_cyc;
    endfunction

endpackage

// File: rtl/rc_servo_core_multi_if.sv
// Pin bundle of the multi-channel servo core.
//   comp_async   : comparator inputs, one per channel
//   en           : per-channel enable
//   pwm_pin      : sigma-delta feedback pins
//   pwm          : servo pulses
//   sample       : latest samples, channel k in [k*ADC_W +: ADC_W]
//   sample_valid : one-cycle strobe when sample updates
// master = the side that drives comparators/enables, slave = the core.
interface rc_servo_core_multi_if #(
    parameter int N_CH  = 2,
    parameter int ADC_W = 8
);
    logic [N_CH-1:0]       comp_async;
    logic [N_CH-1:0]       en;
    logic [N_CH-1:0]       pwm_pin;
    logic [N_CH-1:0]       pwm;
    logic [N_CH*ADC_W-1:0] sample;
    logic                  sample_valid;

    modport master (
        output comp_async, en,
        input  pwm_pin, pwm, sample, sample_valid
    );

    modport slave (
        input  comp_async, en,
        output pwm_pin, pwm, sample, sample_valid
    );
endinterface

// File: rtl/rc_servo_channel.sv
// One servo channel: comparator synchronizer, sigma-delta feedback pin,
// window accumulator, sample register, slew-limited pulse width and the
// registered servo pulse. Timing comes from the shared counters in the top.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   comp_async   : raw comparator input
//   en           : channel enable
//   window_last  : shared window counter is at its last count
//   frame_start  : shared frame counter is 0
//   frame_cnt    : shared frame counter value
//   pwm_pin      : sigma-delta feedback output
//   pwm          : servo pulse output
//   sample       : latest latched sample
module rc_servo_channel
    import rc_servo_pkg::*;
#(
    parameter int ADC_W    = 8,
    parameter int PW_MIN   = 1000,
    parameter int SCALE_SH = 2,
    parameter int SLEW_MAX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             comp_async,
    input  logic             en,
    input  logic             window_last,
    input  logic             frame_start,
    input  pw_t              frame_cnt,
    output logic             pwm_pin,
    output logic             pwm,
    output logic [ADC_W-1:0] sample
);

    localparam pw_t PW_MID = pw_mid(PW_MIN, ADC_W, SCALE_SH);
    localparam pw_t SLEW   = pw_t'(SLEW_MAX);
    localparam logic [ADC_W:0] SAMPLE_MAX = {1'b0, {ADC_W{1'b1}}};

    logic [1:0]       sync_reg;
    logic             comp_sync;
    logic             pin_reg;
    logic             pwm_reg;
    logic             armed_reg;
    logic             have_sample_reg;
    logic [ADC_W:0]   acc_reg;
    logic [ADC_W:0]   acc_total;
    logic [ADC_W-1:0] sample_reg;
    logic [ADC_W-1:0] sample_next;
    pw_t              pw_act_reg;
    pw_t              pw_act_next;
    pw_t              pw_frame;
    pw_t              target;

    assign comp_sync = sync_reg[1];

    // A full window of ones counts to 2^ADC_W, one above the sample range.
    assign acc_total   = acc_reg + {{ADC_W{1'b0}}, comp_sync};
    assign sample_next = (acc_total > SAMPLE_MAX) ? SAMPLE_MAX[ADC_W-1:0]
                                                  : acc_total[ADC_W-1:0];

    // Built from the registered sample, so a sample latching in the same
    // cycle as a frame load only takes effect at the following frame.
    assign target = pw_t'(PW_MIN) + (pw_t'(sample_reg) << SCALE_SH);

    always_comb begin
        pw_act_next = pw_act_reg;
        if (SLEW_MAX == 0) begin
            pw_act_next = target;
        end else if (target > pw_act_reg) begin
            pw_act_next = ((target - pw_act_reg) > SLEW) ? (pw_act_reg + SLEW) : target;
        end else begin
            pw_act_next = ((pw_act_reg - target) > SLEW) ? (pw_act_reg - SLEW) : target;
        end
    end

    // Until a window has completed since reset/enable there is no real
    // measurement, so the width stays at neutral instead of jumping to PW_MIN.
    // At frame start the comparison uses the width being loaded, so each
    // pulse is exactly pw_act cycles long.
    assign pw_frame = (frame_start && have_sample_reg) ? pw_act_next : pw_act_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg        <= '0;
            pin_reg         <= 1'b0;
            pwm_reg         <= 1'b0;
            armed_reg       <= 1'b0;
            have_sample_reg <= 1'b0;
            acc_reg         <= '0;
            sample_reg      <= '0;
            pw_act_reg      <= PW_MID;
        end else begin
            sync_reg <= {sync_reg[0], comp_async};
            pin_reg  <= en & ~comp_sync;
            if (!en) begin
                pwm_reg         <= 1'b0;
                armed_reg       <= 1'b0;
                have_sample_reg <= 1'b0;
                acc_reg         <= '0;
                sample_reg      <= '0;
                pw_act_reg      <= PW_MID;
            end else begin
                if (window_last) begin
                    acc_reg         <= '0;
                    sample_reg      <= sample_next;
                    have_sample_reg <= 1'b1;
                end else begin
                    acc_reg <= acc_total;
                end
                if (frame_start) begin
                    armed_reg <= 1'b1;
                    if (have_sample_reg) begin
                        pw_act_reg <= pw_act_next;
                    end
                end
                // armed_reg keeps a mid-frame enable from emitting a partial pulse.
                pwm_reg <= (armed_reg || frame_start) && (frame_cnt < pw_frame);
            end
        end
    end

    assign pwm_pin = pin_reg;
    assign pwm     = pwm_reg;
    assign sample  = sample_reg;

endmodule

// File: rtl/rc_servo_core_multi.sv
// Multi-channel sigma-delta servo core. One shared window counter paces the
// sigma-delta measurement and one shared frame counter paces the servo
// frames; each channel converts its comparator stream into a sample and a
// pulse width.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   comp_async_i   : comparator inputs, one per channel
//   en_i           : per-channel enable
//   pwm_pin_o      : sigma-delta feedback pins
//   pwm_o          : servo pulses
//   sample_o       : latest samples, channel k in [k*ADC_W +: ADC_W]
//   sample_valid_o : one-cycle strobe when sample_o updates
module rc_servo_core_multi
    import rc_servo_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ADC_W     = 8,
    parameter int FRAME_CYC = 20000,
    parameter int PW_MIN    = 1000,
    parameter int SCALE_SH  = 2,
    parameter int SLEW_MAX  = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [N_CH-1:0]       comp_async_i,
    input  logic [N_CH-1:0]       en_i,
    output logic [N_CH-1:0]       pwm_pin_o,
    output logic [N_CH-1:0]       pwm_o,
    output logic [N_CH*ADC_W-1:0] sample_o,
    output logic                  sample_valid_o
);

    generate
        if (!pw_fits_frame(PW_MIN, ADC_W, SCALE_SH, FRAME_CYC)) begin : g_bad_cfg
            $error("rc_servo_core_multi: widest pulse does not fit inside FRAME_CYC");
        end
    endgenerate

    logic [ADC_W-1:0] win_cnt_reg;
    pw_t              frame_cnt_reg;
    logic             sample_valid_reg;
    logic             window_last;
    logic             frame_start;

    assign window_last = (win_cnt_reg == {ADC_W{1'b1}});
    assign frame_start = (frame_cnt_reg == '0);

    // Both counters sit at 0 during reset, so the first edge after release
    // is the first window cycle and the first frame start.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            win_cnt_reg      <= '0;
            frame_cnt_reg    <= '0;
            sample_valid_reg <= 1'b0;
        end else begin
            win_cnt_reg      <= win_cnt_reg + ADC_W'(1);
            frame_cnt_reg    <= (frame_cnt_reg == pw_t'(FRAME_CYC - 1)) ? '0
                                                                       : frame_cnt_reg + pw_t'(1);
            sample_valid_reg <= window_last;
        end
    end

    assign sample_valid_o = sample_valid_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            rc_servo_channel #(
                .ADC_W    (ADC_W),
                .PW_MIN   (PW_MIN),
                .SCALE_SH (SCALE_SH),
                .SLEW_MAX (SLEW_MAX)
            ) u_ch (
                .clk         (clk_i),
                .rst         (reset_i),
                .comp_async  (comp_async_i[gi]),
                .en          (en_i[gi]),
                .window_last (window_last),
                .frame_start (frame_start),
                .frame_cnt   (frame_cnt_reg),
                .pwm_pin     (pwm_pin_o[gi]),
                .pwm         (pwm_o[gi]),
                .sample      (sample_o[gi*ADC_W +: ADC_W])
            );
        end
    endgenerate

endmodule
